rgb_switch_conditioner: RTL and testbench

//  Upstream stage of the VGA text generator. Conditions the 3 raw board colour

---
 rtl/rgb_switch_conditioner_pkg.sv | 10 +
 rtl/rgb_switch_conditioner_sw_debounce.sv | 56 +++++
 rtl/rgb_switch_conditioner.sv | 111 +++++++++++
 tb/tb_rgb_switch_conditioner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_switch_conditioner_pkg.sv
// Shared constants for the VGA text-generator colour path.
//   RGB_W       : width of the {R,G,B} colour select
//   DEFAULT_RGB : colour shown after reset until the first frame latch (white)
// VGA timing constants stay with the timing generator and are not needed here.
package rgb_switch_conditioner_pkg;

  localparam int unsigned RGB_W = 3;
  localparam logic [RGB_W-1:0] DEFAULT_RGB = 3'b111;

endpackage

// File: rtl/rgb_switch_conditioner_sw_debounce.sv
// sw_debounce: one switch bit, synchronised then debounced.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   raw    in  asynchronous switch bit
//   stable out debounced bit
// A new level is accepted DB_CYCLES cycles after it first appears at the
// synchroniser output; any shorter excursion is discarded.
module rgb_switch_conditioner_sw_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_bit == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = sync_bit;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/rgb_switch_conditioner.sv
// rgb_switch_conditioner: conditions the three board colour switches for the
// VGA text generator and applies a new colour only at the start of vsync.
// Ports:
//   clk        in   system clock (only clock)
//   reset      in   synchronous active-high reset
//   sw_raw     in   asynchronous switches {R,G,B}
//   vsync      in   active-low vertical sync, clk domain
//   sw_stable  out  debounced switch value
//   frame_tick out  1-cycle pulse per vsync falling edge
//   rgb_sel    out  frame-aligned colour select
// Optional feature: define RGB_BLINK_EN to blank rgb_sel every other
// BLINK_FRAMES-frame period.
module rgb_switch_conditioner
  import rgb_switch_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DB_CYCLES    = 1000000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RGB_W-1:0] sw_raw,
  input  logic             vsync,
  output logic [RGB_W-1:0] sw_stable,
  output logic             frame_tick,
  output logic [RGB_W-1:0] rgb_sel
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < 1 || 64'(DB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_db
    $error("DB_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  for (genvar i = 0; i < RGB_W; i++) begin : g_db
    rgb_switch_conditioner_sw_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W)
    ) u_sw_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i])
    );
  end

  logic             vsync_q;
  logic             frame_tick_q;
  logic             frame_edge;
  logic [RGB_W-1:0] snap_q, snap_d;
  logic [RGB_W-1:0] latch_q, latch_d;

  // The switch value is snapshotted on the edge that detects the vsync fall,
  // before any debounce acceptance on that same edge can be seen, so a
  // coincident acceptance waits for the next frame.
  always_comb begin
    frame_edge = vsync_q & ~vsync;
    snap_d     = frame_edge ? sw_stable : snap_q;
    latch_d    = frame_tick_q ? snap_q : latch_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      snap_q       <= DEFAULT_RGB;
      latch_q      <= DEFAULT_RGB;
    end else begin
      vsync_q      <= vsync;
      frame_tick_q <= frame_edge;
      snap_q       <= snap_d;
      latch_q      <= latch_d;
    end
  end

  assign frame_tick = frame_tick_q;

`ifdef RGB_BLINK_EN
  localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(BLINK_FRAMES - 1);

  logic [FcW-1:0] frame_cnt_q;
  logic           blink_phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_tick_q) begin
      if (frame_cnt_q == FcLast) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FcW'(1);
      end
    end
  end

  assign rgb_sel = blink_phase_q ? '0 : latch_q;
`else
  assign rgb_sel = latch_q;
`endif

endmodule

// File: tb/tb_rgb_switch_conditioner.sv
// Self-checking bench for rgb_switch_conditioner (DB_CYCLES=4, BLINK_FRAMES=2).
// A per-cycle vector table covers reset, debounce latency, glitch rejection,
// frame alignment, the acceptance/frame_tick collision and mid-frame reset;
// short hand-written sequences follow for the multi-cycle corners.
module tb_rgb_switch_conditioner;

  typedef struct {
    logic       rst;
    logic [2:0] sw;
    logic       vs;
    logic [2:0] stable;
    logic       tick;
    logic [2:0] rgb;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] sw_raw;
  logic       vsync;
  logic [2:0] sw_stable;
  logic       frame_tick;
  logic [2:0] rgb_sel;

  int n_cmp;
  int n_fail;
  vec_t vq[$];

  rgb_switch_conditioner #(
    .SYNC_STAGES  (2),
    .DB_CYCLES    (4),
    .CNT_W        (3),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .vsync      (vsync),
    .sw_stable  (sw_stable),
    .frame_tick (frame_tick),
    .rgb_sel    (rgb_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] s, input logic v,
                     input logic [2:0] st, input logic t, input logic [2:0] rg,
                     input int reps);
    vec_t e;
    e.rst = r; e.sw = s; e.vs = v; e.stable = st; e.tick = t; e.rgb = rg;
    for (int k = 0; k < reps; k++) vq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b_cnt;
    logic b_phase;
    logic prev_tick;
    logic [2:0] exp_rgb;
    int n;
    int ticks;

    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    sw_raw = 3'b000;
    vsync = 1'b1;

    //   rst sw     vs  stable  tick rgb    reps
    add(1, 3'd0, 1, 3'd0, 0, 3'd7, 3);  // reset held 3 cycles
    add(0, 3'd0, 1, 3'd0, 0, 3'd7, 1);  // release
    add(0, 3'd5, 1, 3'd0, 0, 3'd7, 5);  // 000->101, not yet accepted
    add(0, 3'd5, 1, 3'd5, 0, 3'd7, 1);  // accepted SYNC_STAGES+4 edges later
    add(0, 3'd2, 1, 3'd5, 0, 3'd7, 3);  // 3-cycle glitch
    add(0, 3'd5, 1, 3'd5, 0, 3'd7, 4);  // glitch rejected
    add(0, 3'd5, 0, 3'd5, 1, 3'd7, 1);  // vsync falls: tick
    add(0, 3'd5, 0, 3'd5, 0, 3'd5, 3);  // latched; held low gives no more ticks
    add(0, 3'd5, 1, 3'd5, 0, 3'd5, 1);
    add(0, 3'd3, 1, 3'd5, 0, 3'd5, 5);  // 101->011 debouncing
    add(0, 3'd3, 0, 3'd3, 1, 3'd5, 1);  // acceptance on the tick edge
    add(0, 3'd3, 0, 3'd3, 0, 3'd5, 1);  // old colour latched
    add(0, 3'd3, 1, 3'd3, 0, 3'd5, 1);
    add(0, 3'd3, 0, 3'd3, 1, 3'd5, 1);  // next frame
    add(0, 3'd3, 0, 3'd3, 0, 3'd3, 1);  // new colour now
    add(0, 3'd3, 1, 3'd3, 0, 3'd3, 1);
    add(0, 3'd6, 1, 3'd3, 0, 3'd3, 5);  // 011->110
    add(0, 3'd6, 1, 3'd6, 0, 3'd3, 1);
    add(0, 3'd6, 0, 3'd6, 1, 3'd3, 1);
    add(0, 3'd6, 0, 3'd6, 0, 3'd6, 1);  // rgb_sel=110
    add(1, 3'd6, 0, 3'd0, 0, 3'd7, 1);  // mid-frame reset
    add(0, 3'd6, 0, 3'd0, 1, 3'd7, 1);  // vsync_d resets high, vsync low: tick
    add(0, 3'd6, 1, 3'd0, 0, 3'd0, 4);  // first tick after reset loads 000
    add(0, 3'd6, 1, 3'd6, 0, 3'd0, 1);  // 110 accepted again

    b_cnt = 0;
    b_phase = 1'b0;
    prev_tick = 1'b0;
    foreach (vq[i]) begin
      reset  = vq[i].rst;
      sw_raw = vq[i].sw;
      vsync  = vq[i].vs;
      step();
      if (vq[i].rst) begin
        b_cnt = 0;
        b_phase = 1'b0;
      end else if (prev_tick) begin
        if (b_cnt == 1) begin
          b_cnt = 0;
          b_phase = ~b_phase;
        end else begin
          b_cnt++;
        end
      end
      prev_tick = vq[i].tick;
`ifdef RGB_BLINK_EN
      exp_rgb = b_phase ? 3'b000 : vq[i].rgb;
`else
      exp_rgb = vq[i].rgb;
`endif
      check($sformatf("vec%0d sw_stable", i), {5'd0, sw_stable}, {5'd0, vq[i].stable});
      check($sformatf("vec%0d frame_tick", i), {7'd0, frame_tick}, {7'd0, vq[i].tick});
      check($sformatf("vec%0d rgb_sel", i), {5'd0, rgb_sel}, {5'd0, exp_rgb});
    end

    // Debounce latency measured directly: 110 -> 001, all bits change.
    sw_raw = 3'b001;
    n = 21;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sw_stable == 3'b001) begin
        n = k;
        break;
      end
    end
    check("debounce latency", 8'(n), 8'd6);

    // vsync held low for many cycles: exactly one tick.
    vsync = 1'b0;
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (frame_tick) ticks++;
    end
    check("held-low tick count", 8'(ticks), 8'd1);
`ifndef RGB_BLINK_EN
    check("held-low rgb_sel", {5'd0, rgb_sel}, 8'd1);
`endif
    vsync = 1'b1;
    step();
    check("tick idle after rise", {7'd0, frame_tick}, 8'd0);

`ifdef RGB_BLINK_EN
    begin
      logic [2:0] m_latch;
      int m_cnt;
      logic m_phase;
      reset = 1'b1;
      step();
      reset = 1'b0;
      sw_raw = 3'b010;
      for (int k = 0; k < 8; k++) step();
      check("blink setup sw_stable", {5'd0, sw_stable}, 8'd2);
      m_latch = 3'b111;
      m_cnt = 0;
      m_phase = 1'b0;
      for (int f = 0; f < 6; f++) begin
        vsync = 1'b0;
        step();
        check($sformatf("blink tick%0d", f), {7'd0, frame_tick}, 8'd1);
        check($sformatf("blink rgb%0d", f), {5'd0, rgb_sel},
              {5'd0, (m_phase ? 3'b000 : m_latch)});
        m_latch = 3'b010;
        if (m_cnt == 1) begin
          m_cnt = 0;
          m_phase = ~m_phase;
        end else begin
          m_cnt++;
        end
        vsync = 1'b1;
        step();
        step();
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
